// File: rtl/qspi_mem_arbiter_if.sv
// Bus bundle between the two CPU Wishbone masters, the arbiter and the QSPI controller.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface qspi_mem_arbiter_if;
   logic        ibus_stb_i;
   logic [24:0] ibus_adr_i;
   logic        ibus_ack_o;
   logic [31:0] ibus_dat_o;

   logic        dbus_stb_i;
   logic        dbus_we_i;
   logic [3:0]  dbus_be_i;
   logic [24:0] dbus_adr_i;
   logic [31:0] dbus_dat_i;
   logic        dbus_ack_o;
   logic [31:0] dbus_dat_o;

   logic        mem_stb_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [21:0] mem_adr_o;
   logic [31:0] mem_dat_o;
   logic        mem_sel_rom_ram_o;
   logic        mem_ack_i;
   logic [31:0] mem_dat_i;

   logic        wp_viol_o;

   modport slave (
      input  ibus_stb_i, ibus_adr_i,
      output ibus_ack_o, ibus_dat_o,
      input  dbus_stb_i, dbus_we_i, dbus_be_i, dbus_adr_i, dbus_dat_i,
      output dbus_ack_o, dbus_dat_o,
      output mem_stb_o, mem_we_o, mem_be_o, mem_adr_o, mem_dat_o, mem_sel_rom_ram_o,
      input  mem_ack_i, mem_dat_i,
      output wp_viol_o
   );

   modport master (
      output ibus_stb_i, ibus_adr_i,
      input  ibus_ack_o, ibus_dat_o,
      output dbus_stb_i, dbus_we_i, dbus_be_i, dbus_adr_i, dbus_dat_i,
      input  dbus_ack_o, dbus_dat_o,
      input  mem_stb_o, mem_we_o, mem_be_o, mem_adr_o, mem_dat_o, mem_sel_rom_ram_o,
      output mem_ack_i, mem_dat_i,
      input  wp_viol_o
   );
endinterface

// File: rtl/qspi_mem_arbiter.sv
// Two-master (ibus/dbus) arbiter and request latch in front of the shared QSPI memory controller.
// Optional ROM write protection is enabled by defining QSPI_ARB_ROM_WP_EN.
module qspi_mem_arbiter #(
   parameter int unsigned FAIR_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_in,
   qspi_mem_arbiter_if.slave bus
);

   localparam int unsigned      FCW      = $clog2(FAIR_LIMIT + 1);
   localparam logic [FCW-1:0]   FAIR_MAX = FCW'(FAIR_LIMIT);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BUSY_I = 3'd1,
      ST_BUSY_D = 3'd2,
`ifdef QSPI_ARB_ROM_WP_EN
      ST_WP_ACK = 3'd3,
`endif
      ST_GAP    = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              mem_stb_q, mem_stb_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [21:0]       mem_adr_q, mem_adr_d;
   logic [31:0]       mem_dat_q, mem_dat_d;
   logic              mem_sel_q, mem_sel_d;
   logic [FCW-1:0]    fair_cnt_q, fair_cnt_d;
`ifdef QSPI_ARB_ROM_WP_EN
   logic              wp_viol_q, wp_viol_d;
   logic              wp_hit_s;
`endif

   logic              pick_d_s;
   logic              pick_i_s;
   logic              ibus_ack_s;
   logic              dbus_ack_s;
   logic [31:0]       dbus_dat_s;
   logic              unused_s;

   // Word-aligned controller: the byte-offset bits never reach it.
   assign unused_s = ^{bus.ibus_adr_i[1:0], bus.dbus_adr_i[1:0]};

   // Registers: FSM state, latched request and fairness counter.
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= ST_IDLE;
         mem_stb_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_be_q   <= 4'hF;
         mem_adr_q  <= 22'd0;
         mem_dat_q  <= 32'd0;
         mem_sel_q  <= 1'b0;
         fair_cnt_q <= '0;
`ifdef QSPI_ARB_ROM_WP_EN
         wp_viol_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         mem_stb_q  <= mem_stb_d;
         mem_we_q   <= mem_we_d;
         mem_be_q   <= mem_be_d;
         mem_adr_q  <= mem_adr_d;
         mem_dat_q  <= mem_dat_d;
         mem_sel_q  <= mem_sel_d;
         fair_cnt_q <= fair_cnt_d;
`ifdef QSPI_ARB_ROM_WP_EN
         wp_viol_q  <= wp_viol_d;
`endif
      end
   end

   // Arbitration: dbus has priority until ibus has waited FAIR_LIMIT dbus grants.
   always_comb begin
      pick_d_s = 1'b0;
      pick_i_s = 1'b0;
      if (state_q == ST_IDLE) begin
         if (bus.dbus_stb_i && !(bus.ibus_stb_i && (fair_cnt_q == FAIR_MAX))) begin
            pick_d_s = 1'b1;
         end else if (bus.ibus_stb_i) begin
            pick_i_s = 1'b1;
         end else begin
            pick_i_s = 1'b0;
         end
      end else begin
         pick_d_s = 1'b0;
      end
`ifdef QSPI_ARB_ROM_WP_EN
      wp_hit_s = pick_d_s && bus.dbus_we_i && !bus.dbus_adr_i[24];
`endif
   end

   // Next state and next values of the latched controller request.
   always_comb begin
      state_d    = state_q;
      mem_stb_d  = mem_stb_q;
      mem_we_d   = mem_we_q;
      mem_be_d   = mem_be_q;
      mem_adr_d  = mem_adr_q;
      mem_dat_d  = mem_dat_q;
      mem_sel_d  = mem_sel_q;
      fair_cnt_d = fair_cnt_q;
`ifdef QSPI_ARB_ROM_WP_EN
      wp_viol_d  = wp_viol_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!bus.ibus_stb_i) begin
               fair_cnt_d = '0;
            end else begin
               fair_cnt_d = fair_cnt_q;
            end
            if (pick_d_s) begin
               if (bus.ibus_stb_i && (fair_cnt_q != FAIR_MAX)) begin
                  fair_cnt_d = fair_cnt_q + FCW'(1);
               end else begin
                  fair_cnt_d = fair_cnt_d;
               end
`ifdef QSPI_ARB_ROM_WP_EN
               // Blocked ROM write: answered locally, controller never sees it.
               if (wp_hit_s) begin
                  state_d   = ST_WP_ACK;
                  wp_viol_d = 1'b1;
               end else
`endif
               begin
                  state_d   = ST_BUSY_D;
                  mem_stb_d = 1'b1;
                  mem_we_d  = bus.dbus_we_i;
                  mem_be_d  = bus.dbus_be_i;
                  mem_adr_d = bus.dbus_adr_i[23:2];
                  mem_dat_d = bus.dbus_dat_i;
                  mem_sel_d = bus.dbus_adr_i[24];
               end
            end else if (pick_i_s) begin
               fair_cnt_d = '0;
               state_d    = ST_BUSY_I;
               mem_stb_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_be_d   = 4'hF;
               mem_adr_d  = bus.ibus_adr_i[23:2];
               mem_sel_d  = bus.ibus_adr_i[24];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (bus.mem_ack_i) begin
               mem_stb_d = 1'b0;
               state_d   = ST_GAP;
            end else begin
               state_d = state_q;
            end
         end
`ifdef QSPI_ARB_ROM_WP_EN
         ST_WP_ACK: state_d = ST_GAP;
`endif
         ST_GAP:    state_d = ST_IDLE;
         default: begin
            state_d   = ST_IDLE;
            mem_stb_d = 1'b0;
         end
      endcase
   end

   // Acknowledge routing to the granted master.
   always_comb begin
      ibus_ack_s = 1'b0;
      dbus_ack_s = 1'b0;
      dbus_dat_s = bus.mem_dat_i;
      case (state_q)
         ST_BUSY_I: ibus_ack_s = bus.mem_ack_i;
         ST_BUSY_D: dbus_ack_s = bus.mem_ack_i;
`ifdef QSPI_ARB_ROM_WP_EN
         ST_WP_ACK: begin
            dbus_ack_s = 1'b1;
            dbus_dat_s = 32'd0;
         end
`endif
         default: begin
            ibus_ack_s = 1'b0;
            dbus_ack_s = 1'b0;
         end
      endcase
   end

   assign bus.ibus_ack_o        = ibus_ack_s;
   assign bus.ibus_dat_o        = bus.mem_dat_i;
   assign bus.dbus_ack_o        = dbus_ack_s;
   assign bus.dbus_dat_o        = dbus_dat_s;
   assign bus.mem_stb_o         = mem_stb_q;
   assign bus.mem_we_o          = mem_we_q;
   assign bus.mem_be_o          = mem_be_q;
   assign bus.mem_adr_o         = mem_adr_q;
   assign bus.mem_dat_o         = mem_dat_q;
   assign bus.mem_sel_rom_ram_o = mem_sel_q;
`ifdef QSPI_ARB_ROM_WP_EN
   assign bus.wp_viol_o         = wp_viol_q;
`else
   assign bus.wp_viol_o         = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Scoreboard bench for qspi_mem_arbiter: request records and expected grant order are queued by
// the stimulus; a negedge monitor pops and compares whenever the DUT grants or acknowledges.
module tb_qspi_mem_arbiter;
   localparam int unsigned FL = 4;
   localparam byte unsigned K_I = 8'h49;
   localparam byte unsigned K_D = 8'h44;
   localparam byte unsigned K_W = 8'h57;

   typedef struct {
      bit          is_d;
      logic        we;
      logic [3:0]  be;
      logic [24:0] adr;
      logic [31:0] dat;
      int          req_cyc;
      bit          solo;
      bit          b2b;
   } req_t;

   logic clk = 1'b0;
   logic rst_n;
   qspi_mem_arbiter_if bus();

   qspi_mem_arbiter #(.FAIR_LIMIT(FL)) dut (
      .clk_i  (clk),
      .rst_in (rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   req_t         iq[$];
   req_t         dq[$];
   byte unsigned order_q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           fixed_lat = 0;
   bit           inject_ack = 1'b0;
   bit           gap_pulse = 1'b0;
   logic [31:0]  ctl_word = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Controller model: acks after a per-transaction latency, plus injected stray acks.
   initial begin : ctl
      int cnt;
      int lat;
      cnt = 0;
      lat = 1;
      bus.mem_ack_i = 1'b0;
      bus.mem_dat_i = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            bus.mem_ack_i = 1'b0;
            cnt = 0;
         end else if (bus.mem_ack_i) begin
            if (gap_pulse) begin
               gap_pulse = 1'b0;
               bus.mem_dat_i = $urandom;
            end else begin
               bus.mem_ack_i = 1'b0;
            end
         end else if (inject_ack) begin
            inject_ack = 1'b0;
            bus.mem_ack_i = 1'b1;
            bus.mem_dat_i = $urandom;
         end else if (bus.mem_stb_o) begin
            if (cnt == 0) lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
            cnt++;
            if (cnt >= lat) begin
               cnt = 0;
               ctl_word = $urandom;
               bus.mem_dat_i = ctl_word;
               bus.mem_ack_i = 1'b1;
            end
         end
      end
   end

   // Monitor: grant and acknowledge checking against the queued expectations.
   initial begin : mon
      bit           prev_stb;
      bit           busy;
      bit           stable;
      byte unsigned m;
      req_t         r;
      logic [31:0]  last_mem_dat;
      int           last_ack;
      logic [62:0]  snap;
      prev_stb = 1'b0; busy = 1'b0; stable = 1'b0; m = K_I;
      last_mem_dat = 32'd0; last_ack = -100; snap = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stb = 1'b0; busy = 1'b0;
            iq.delete(); dq.delete(); order_q.delete();
            last_mem_dat = 32'd0; last_ack = -100;
         end else begin
            if (bus.mem_stb_o && !prev_stb) begin
               if (order_q.size() == 0) begin
                  check("unexpected_grant", 32'd1, 32'd0);
               end else begin
                  m = order_q.pop_front();
                  check("grant_not_wp_blocked", {31'd0, m == K_W}, 32'd0);
                  if ((m == K_I && iq.size() == 0) || (m != K_I && dq.size() == 0)) begin
                     check("grant_without_request", 32'd1, 32'd0);
                  end else begin
                     r = (m == K_I) ? iq.pop_front() : dq.pop_front();
                     check("mem_we", bus.mem_we_o, r.is_d ? r.we : 1'b0);
                     check("mem_be", bus.mem_be_o, r.is_d ? r.be : 4'hF);
                     check("mem_adr", bus.mem_adr_o, r.adr[23:2]);
                     check("mem_sel", bus.mem_sel_rom_ram_o, r.adr[24]);
                     check("mem_dat", bus.mem_dat_o, r.is_d ? r.dat : last_mem_dat);
                     if (r.solo) check("grant_latency", cyc - r.req_cyc, 32'd1);
                     if (r.b2b) check("stb_spacing", cyc - last_ack, 32'd3);
                     else check("stb_spacing_min", {31'd0, (cyc - last_ack) >= 3}, 32'd1);
                     if (r.is_d) last_mem_dat = r.dat;
                  end
                  snap = {bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o, bus.mem_dat_o, bus.mem_sel_rom_ram_o};
                  stable = 1'b1;
                  busy = 1'b1;
               end
            end else if (bus.mem_stb_o) begin
               if (snap !== {bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o, bus.mem_dat_o,
                             bus.mem_sel_rom_ram_o}) stable = 1'b0;
            end
            if (bus.mem_stb_o && bus.mem_ack_i && busy) begin
               check("ibus_ack", bus.ibus_ack_o, m == K_I);
               check("dbus_ack", bus.dbus_ack_o, m == K_D);
               if (m == K_I) check("ibus_dat", bus.ibus_dat_o, ctl_word);
               else check("dbus_dat", bus.dbus_dat_o, ctl_word);
               check("mem_held_stable", stable, 1'b1);
               last_ack = cyc;
               busy = 1'b0;
            end
`ifdef QSPI_ARB_ROM_WP_EN
            else if (bus.dbus_ack_o && !bus.mem_stb_o && order_q.size() > 0 && dq.size() > 0) begin
               m = order_q.pop_front();
               r = dq.pop_front();
               check("wp_kind", {31'd0, m == K_W}, 32'd1);
               check("wp_ack_latency", cyc - r.req_cyc, 32'd1);
               check("wp_dat_zero", bus.dbus_dat_o, 32'd0);
               check("wp_viol_set", bus.wp_viol_o, 1'b1);
               check("wp_no_ibus_ack", bus.ibus_ack_o, 1'b0);
               last_ack = cyc;
            end
`endif
            else if (bus.ibus_ack_o || bus.dbus_ack_o || bus.mem_ack_i) begin
               check("no_stray_ack", {bus.ibus_ack_o, bus.dbus_ack_o}, 32'd0);
            end
            prev_stb = bus.mem_stb_o;
         end
      end
   end

   // One master transaction: raise stb, queue expectation, hold until ack, drop.
   task automatic do_req(input bit is_d, input logic we, input logic [3:0] be,
                         input logic [24:0] adr, input logic [31:0] dat,
                         input bit solo, input bit b2b);
      req_t r;
      bit   got;
      @(posedge clk);
      #1;
      r.is_d = is_d; r.we = we; r.be = be; r.adr = adr; r.dat = dat;
      r.req_cyc = cyc; r.solo = solo; r.b2b = b2b;
      if (is_d) begin
         bus.dbus_stb_i = 1'b1; bus.dbus_we_i = we; bus.dbus_be_i = be;
         bus.dbus_adr_i = adr; bus.dbus_dat_i = dat;
         dq.push_back(r);
      end else begin
         bus.ibus_stb_i = 1'b1; bus.ibus_adr_i = adr;
         iq.push_back(r);
      end
      if (solo) begin
`ifdef QSPI_ARB_ROM_WP_EN
         order_q.push_back(!is_d ? K_I : ((we && !adr[24]) ? K_W : K_D));
`else
         order_q.push_back(is_d ? K_D : K_I);
`endif
      end
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         got = is_d ? bus.dbus_ack_o : bus.ibus_ack_o;
      end
      if (!got) check(is_d ? "dbus_ack_timeout" : "ibus_ack_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (is_d) begin
         bus.dbus_stb_i = 1'b0; bus.dbus_we_i = 1'b0;
      end else begin
         bus.ibus_stb_i = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_stb"}, bus.mem_stb_o, 1'b0);
      check({tag, "_mem_we"}, bus.mem_we_o, 1'b0);
      check({tag, "_mem_be"}, bus.mem_be_o, 4'hF);
      check({tag, "_mem_adr"}, bus.mem_adr_o, 22'd0);
      check({tag, "_mem_dat"}, bus.mem_dat_o, 32'd0);
      check({tag, "_mem_sel"}, bus.mem_sel_rom_ram_o, 1'b0);
      check({tag, "_acks"}, {bus.ibus_ack_o, bus.dbus_ack_o}, 32'd0);
      check({tag, "_wp_viol"}, bus.wp_viol_o, 1'b0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // Main stimulus sequence.
   initial begin : stim
      logic [24:0] a;
      bus.ibus_stb_i = 1'b0; bus.ibus_adr_i = 25'd0;
      bus.dbus_stb_i = 1'b0; bus.dbus_we_i = 1'b0; bus.dbus_be_i = 4'hF;
      bus.dbus_adr_i = 25'd0; bus.dbus_dat_i = 32'd0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      fixed_lat = 20;
      do_req(1'b0, 1'b0, 4'hF, 25'h0000100, 32'd0, 1'b1, 1'b0);
      fixed_lat = 0;
      do_req(1'b1, 1'b1, 4'b1000, 25'h1000003, 32'hAB000000, 1'b1, 1'b0);
      do_req(1'b1, 1'b1, 4'hF, 25'h0000010, 32'h12345678, 1'b1, 1'b0);

      for (int k = 0; k < 16; k++) begin
         a = 25'($urandom);
         if ($urandom_range(0, 1) == 0) do_req(1'b0, 1'b0, 4'hF, a, 32'd0, 1'b1, 1'b0);
         else do_req(1'b1, 1'($urandom), 4'($urandom_range(1, 15)), a, $urandom, 1'b1, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      inject_ack = 1'b1;
      repeat (4) @(posedge clk);
      do_req(1'b0, 1'b0, 4'hF, 25'h1ABCDE4, 32'd0, 1'b1, 1'b0);
      gap_pulse = 1'b1;
      do_req(1'b1, 1'b0, 4'h3, 25'h1000400, 32'h5A5A0001, 1'b1, 1'b0);
      do_req(1'b0, 1'b0, 4'hF, 25'h0000404, 32'd0, 1'b1, 1'b0);

      repeat (3) @(posedge clk);
      for (int k = 0; k < 10; k++) order_q.push_back(((k % (FL + 1)) == FL) ? K_I : K_D);
      fork
         begin
            for (int kd = 0; kd < 8; kd++) begin
               a = {1'b1, 24'($urandom)};
               do_req(1'b1, 1'($urandom), 4'($urandom_range(1, 15)), a, $urandom, 1'b0, kd > 0);
            end
         end
         begin
            for (int ki = 0; ki < 2; ki++) do_req(1'b0, 1'b0, 4'hF, 25'($urandom), 32'd0, 1'b0, 1'b1);
         end
      join

`ifdef QSPI_ARB_ROM_WP_EN
      check("wp_viol_sticky", bus.wp_viol_o, 1'b1);
`else
      check("wp_viol_tied_low", bus.wp_viol_o, 1'b0);
`endif

      fixed_lat = 50;
      @(posedge clk);
      #1;
      bus.dbus_stb_i = 1'b1; bus.dbus_we_i = 1'b1; bus.dbus_be_i = 4'hF;
      bus.dbus_adr_i = 25'h1000040; bus.dbus_dat_i = 32'hCAFEF00D;
      dq.push_back('{1'b1, 1'b1, 4'hF, 25'h1000040, 32'hCAFEF00D, cyc, 1'b1, 1'b0});
      order_q.push_back(K_D);
      repeat (4) @(posedge clk);
      #1;
      check("busy_before_reset", bus.mem_stb_o, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midbusy_reset");
      bus.dbus_stb_i = 1'b0; bus.dbus_we_i = 1'b0;
      fixed_lat = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_req(1'b0, 1'b0, 4'hF, 25'h0000200, 32'd0, 1'b1, 1'b0);

      repeat (5) @(posedge clk);
      check("queues_drained", order_q.size() + iq.size() + dq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
